// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, ALU, address mux and sticky halt.
// ZERO_REG_EN: define to register the zero flag (one-cycle lag, reset 1).
module cpu_datapath (
    input  logic       clk,
    input  logic       rst_,
    input  logic       load_ir,
    input  logic       inc_pc,
    input  logic       load_pc,
    input  logic       load_ac,
    input  logic       mem_rd,
    input  logic       mem_wr,
    input  logic       halt,
    input  logic       fetch,
    input  logic [7:0] mem_rdata,
    output logic [2:0] opcode,
    output logic       zero,
    output logic [4:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_re,
    output logic       mem_we,
    output logic [4:0] pc,
    output logic [7:0] ac,
    output logic       halted
);

    logic [7:0] ir;
    logic [4:0] operand;
    logic [7:0] alu_res;

    assign opcode  = ir[7:5];
    assign operand = ir[4:0];

    always_comb begin
        alu_res = ac;
        case (opcode)
            3'b000:  alu_res = ac + mem_rdata;
            3'b001:  alu_res = ac & mem_rdata;
            3'b010:  alu_res = ac ^ mem_rdata;
            3'b011:  alu_res = mem_rdata;
            default: alu_res = ac;
        endcase
    end

    // halt is sampled with halted still 0, so same-edge loads still land
    always_ff @(posedge clk) begin
        if (!rst_) begin
            pc     <= 5'd0;
            ir     <= 8'd0;
            ac     <= 8'd0;
            halted <= 1'b0;
        end else begin
            if (halt)
                halted <= 1'b1;
            if (!halted) begin
                if (load_ir)
                    ir <= mem_rdata;
                if (load_pc)
                    pc <= operand;
                else if (inc_pc)
                    pc <= pc + 5'd1;
                if (load_ac)
                    ac <= alu_res;
            end
        end
    end

`ifdef ZERO_REG_EN
    logic zero_q;

    always_ff @(posedge clk) begin
        if (!rst_)
            zero_q <= 1'b1;
        else
            zero_q <= (ac == 8'd0);
    end

    assign zero = zero_q;
`else
    assign zero = (ac == 8'd0);
`endif

    assign mem_addr  = fetch ? pc : operand;
    assign mem_wdata = ac;
    assign mem_re    = mem_rd;
    assign mem_we    = mem_wr & ~halted;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: behavioural model, per-cycle compare, directed
// vectors with literal expectations, then a pseudo-random soak.
module tb_cpu_datapath;

    logic       clk = 1'b0;
    logic       rst_;
    logic       load_ir, inc_pc, load_pc, load_ac;
    logic       mem_rd, mem_wr, halt, fetch;
    logic [7:0] mem_rdata;
    logic [2:0] opcode;
    logic       zero;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_re, mem_we;
    logic [4:0] pc;
    logic [7:0] ac;
    logic       halted;

    int tests  = 0;
    int errors = 0;

    cpu_datapath dut (
        .clk      (clk),
        .rst_     (rst_),
        .load_ir  (load_ir),
        .inc_pc   (inc_pc),
        .load_pc  (load_pc),
        .load_ac  (load_ac),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .halt     (halt),
        .fetch    (fetch),
        .mem_rdata(mem_rdata),
        .opcode   (opcode),
        .zero     (zero),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_re   (mem_re),
        .mem_we   (mem_we),
        .pc       (pc),
        .ac       (ac),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    // Architectural state held as plain integers
    int m_pc, m_ir, m_ac, m_zero_prev;
    bit m_halted;
    bit m_valid = 1'b0;

    function automatic int alu(int op, int a, int d);
        if (op == 0) return (a + d) % 256;
        if (op == 1) return a & d;
        if (op == 2) return a ^ d;
        if (op == 3) return d;
        return a;
    endfunction

    always @(posedge clk) begin
        if (rst_ === 1'b0) begin
            m_pc        <= 0;
            m_ir        <= 0;
            m_ac        <= 0;
            m_halted    <= 1'b0;
            m_zero_prev <= 1;
            m_valid     <= 1'b1;
        end else begin
            m_zero_prev <= (m_ac == 0) ? 1 : 0;
            if (halt) m_halted <= 1'b1;
            if (!m_halted) begin
                if (load_ir) m_ir <= int'(mem_rdata);
                if (load_pc) m_pc <= m_ir % 32;
                else if (inc_pc) m_pc <= (m_pc + 1) % 32;
                if (load_ac) m_ac <= alu(m_ir / 32, m_ac, int'(mem_rdata));
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_zero();
`ifdef ZERO_REG_EN
        return m_zero_prev;
`else
        return (m_ac == 0) ? 1 : 0;
`endif
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_pc",     int'(pc),        m_pc);
            check("m_ac",     int'(ac),        m_ac);
            check("m_opcode", int'(opcode),    m_ir / 32);
            check("m_halted", int'(halted),    int'(m_halted));
            check("m_zero",   int'(zero),      exp_zero());
            check("m_addr",   int'(mem_addr),  fetch ? m_pc : m_ir % 32);
            check("m_wdata",  int'(mem_wdata), m_ac);
            check("m_re",     int'(mem_re),    int'(mem_rd));
            check("m_we",     int'(mem_we),    int'(mem_wr && !m_halted));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        load_ir = 0; inc_pc = 0; load_pc = 0; load_ac = 0;
        mem_rd = 0; mem_wr = 0; halt = 0; fetch = 1;
    endtask

    task automatic ld_ir(input logic [7:0] v);
        idle(); load_ir = 1; mem_rdata = v; cyc(); idle();
    endtask

    task automatic ld_ac(input logic [7:0] v);
        idle(); load_ac = 1; mem_rdata = v; cyc(); idle();
    endtask

    initial begin
        rst_ = 0; mem_rdata = 8'h00; idle();
        cyc();
        check("rst_pc", int'(pc), 0);
        check("rst_ac", int'(ac), 0);
        check("rst_zero", int'(zero), 1);
        check("rst_halted", int'(halted), 0);
        rst_ = 1;

        ld_ir(8'hA7);
        fetch = 0; #1;
        check("ir_opcode", int'(opcode), 5);
        check("ir_operand", int'(mem_addr), 7);
        check("ir_pc", int'(pc), 0);
        check("ir_ac", int'(ac), 0);
        check("ir_zero", int'(zero), 1);
        fetch = 1;

        ld_ir(8'h1F);
        load_pc = 1; cyc(); idle();
        check("pc_load31", int'(pc), 31);
        inc_pc = 1; cyc(); idle();
        check("pc_wrap", int'(pc), 0);
        ld_ir(8'h05);
        load_pc = 1; inc_pc = 1; cyc(); idle();
        check("pc_prio", int'(pc), 5);

        ld_ir(8'h60);
        ld_ac(8'hF0);
        check("lda_f0", int'(ac), 8'hF0);
        ld_ir(8'h00);
        ld_ac(8'h20);
        check("add_carry", int'(ac), 8'h10);
        ld_ir(8'h40);
        ld_ac(8'h10);
        check("xor_ac", int'(ac), 0);
`ifdef ZERO_REG_EN
        check("xor_zero_lag", int'(zero), 0);
        cyc();
`endif
        check("xor_zero", int'(zero), 1);
        ld_ir(8'h20);
        ld_ac(8'h0F);
        check("and_ac", int'(ac), 0);

        ld_ir(8'h69);
        ld_ac(8'h3C);
        fetch = 0; mem_wr = 1; mem_rd = 1; #1;
        check("st_addr", int'(mem_addr), 9);
        check("st_we", int'(mem_we), 1);
        check("st_wdata", int'(mem_wdata), 8'h3C);
        check("st_re", int'(mem_re), 1);
        fetch = 1; #1;
        check("fetch_addr", int'(mem_addr), 5);

        idle(); halt = 1; load_ac = 1; mem_rdata = 8'h01; cyc(); idle();
        check("halt_set", int'(halted), 1);
        check("halt_same_edge_ac", int'(ac), 8'h01);
        for (int i = 0; i < 3; i++) begin
            load_ir = 1; inc_pc = 1; mem_wr = 1; load_ac = 1;
            mem_rdata = 8'hFF; cyc();
            check("frz_pc", int'(pc), 5);
            check("frz_op", int'(opcode), 3);
            check("frz_ac", int'(ac), 8'h01);
            check("frz_we", int'(mem_we), 0);
            check("frz_halted", int'(halted), 1);
        end
        idle();

        rst_ = 0; load_ac = 1; load_ir = 1; inc_pc = 1; cyc();
        rst_ = 1; idle();
        check("rst_halt_clr", int'(halted), 0);
        check("rst_halt_pc", int'(pc), 0);
        check("rst_halt_ac", int'(ac), 0);
        check("rst_halt_zero", int'(zero), 1);

        for (int i = 0; i < 400; i++) begin
            rst_      = ($urandom_range(0, 39) != 0);
            load_ir   = $urandom_range(0, 1);
            inc_pc    = $urandom_range(0, 1);
            load_pc   = ($urandom_range(0, 3) == 0);
            load_ac   = $urandom_range(0, 1);
            mem_rd    = $urandom_range(0, 1);
            mem_wr    = $urandom_range(0, 1);
            halt      = ($urandom_range(0, 59) == 0);
            fetch     = $urandom_range(0, 1);
            mem_rdata = 8'($urandom_range(0, 255));
            cyc();
        end
        rst_ = 1; idle(); cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have port: clk  input  1  single clock; every register updates on its rising edge.
REQ-002 SHALL have port: rst_  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: load_ir  input  1  load the instruction register from mem_rdata.
REQ-004 SHALL have port: inc_pc  input  1  increment the program counter.
REQ-005 SHALL have port: load_pc  input  1  load the program counter from the IR operand field.
REQ-006 SHALL have port: load_ac  input  1  write the ALU result to the accumulator.
REQ-007 SHALL have port: mem_rd  input  1  memory read strobe from the controller.
REQ-008 SHALL have port: mem_wr  input  1  memory write strobe from the controller.
REQ-009 SHALL have port: halt  input  1  halt request from the controller.
REQ-010 SHALL have port: fetch  input  1  address select; 1 = PC, 0 = IR operand.
REQ-011 SHALL have port: mem_rdata  input  8  memory read data.
REQ-012 SHALL have port: opcode  output  3  ir[7:5]; feeds the controller.
REQ-013 SHALL have port: zero  output  1  accumulator-is-zero flag; feeds the controller.
REQ-014 SHALL have port: mem_addr  output  5  memory address.
REQ-015 SHALL have port: mem_wdata  output  8  memory write data (= AC).
REQ-016 SHALL have port: mem_re  output  1  memory read enable.
REQ-017 SHALL have port: mem_we  output  1  memory write enable.
REQ-018 SHALL have port: pc  output  5  current program counter.
REQ-019 SHALL have port: ac  output  8  current accumulator.
REQ-020 SHALL have port: halted  output  1  sticky halt status.

Function
REQ-021 SHALL load the IR with mem_rdata on a clock edge where load_ir=1 and halted=0.
REQ-022 SHALL treat ir[4:0] as the operand field.
REQ-023 SHALL update the PC at each edge with halted=0, using this priority:
- load_pc=1: PC <= operand; load_pc wins when load_pc and inc_pc are both 1.
- inc_pc=1 only: PC <= PC+1, modulo 32 (31 wraps to 0).
- otherwise: PC holds.
REQ-024 SHALL, on load_ac=1 with halted=0, write the AC by opcode:
- 000 ADD: AC+mem_rdata mod 256, carry discarded.
- 001 AND: AC & mem_rdata.
- 010 XOR: AC ^ mem_rdata.
- 011 LDA: mem_rdata.
- 100-111: AC holds.
REQ-025 SHALL drive mem_addr = fetch ? PC : operand, combinationally.
REQ-026 SHALL drive mem_wdata = AC.
REQ-027 SHALL drive mem_re = mem_rd.
REQ-028 SHALL drive mem_we = mem_wr & ~halted.
REQ-029 SHALL set halted at the edge where halt=1; halted stays 1 until reset.
REQ-030 SHALL, while halted=1, freeze PC, IR and AC regardless of the load and inc inputs.
REQ-031 SHALL act on halt, load_pc and load_ac in the same cycle: the loads take effect at that edge and freeze from the next cycle on.

Reset
REQ-032 SHALL, at an edge with rst_=0, set PC=0, IR=0, AC=0 and halted=0; zero then reads 1.
REQ-033 SHALL give reset priority over every other input, including reset arriving mid-instruction or while halted.

Configuration
REQ-034 SHALL use the macro ZERO_REG_EN to choose how zero is generated:
- Defined: zero is a register loaded with (AC==0) each edge, so it lags AC by one cycle; reset value 1.
- Undefined: zero = (AC==0), combinational, with no lag.

Verification
REQ-035 SHALL cover reset then load: rst_=0 for one edge, then load_ir=1 with mem_rdata=8'hA7 -> opcode=3'b101, operand=7, PC=0, AC=0, zero=1.
REQ-036 SHALL cover PC wrap and priority:
- inc_pc=1 at PC=31 -> PC=0.
- load_pc=1 and inc_pc=1 with operand=5 -> PC=5.
REQ-037 SHALL cover the ALU:
- LDA 8'hF0, then ADD 8'h20 -> AC=8'h10 (carry dropped).
- XOR 8'h10 -> AC=0 and zero=1 (one cycle later under ZERO_REG_EN).
REQ-038 SHALL cover address mux and store: fetch=0, operand=9, mem_wr=1, AC=8'h3C -> mem_addr=9, mem_we=1, mem_wdata=8'h3C.
REQ-039 SHALL cover halt: pulse halt=1, then load_ir, inc_pc and mem_wr all 1 for 3 cycles -> PC, IR and AC unchanged, mem_we=0, halted=1 until rst_=0.
